// File: rtl/d_cache_pkg.sv
// Shared types and helpers for the write-back PLRU data cache.
// Holds the controller state encoding, CPU access size codes and the store byte-lane mask.
package d_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RF   = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Size code 3 falls into the default branch and behaves as a full word.
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: byte_mask = 4'b0001 << off;
            SIZE_HALF: byte_mask = off[1] ? 4'b1100 : 4'b0011;
            default:   byte_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree pseudo-LRU for one set.
// Node 0 is the root and node n has children 2n+1 (left) and 2n+2 (right).
module plru_tree #(
    parameter int WAY_BITS = 2
) (
    input  logic [(1<<WAY_BITS)-2:0] tree_bits,
    input  logic [WAY_BITS-1:0]      hit_way,
    output logic [WAY_BITS-1:0]      victim_way,
    output logic [(1<<WAY_BITS)-2:0] next_bits
);

    localparam int IDXW = (WAY_BITS > 1) ? WAY_BITS : 1;

    // Victim: follow the node bits down, 0 = left, 1 = right.
    always_comb begin : victim_walk
        int   node;
        logic b;
        victim_way = '0;
        node       = 0;
        b          = 1'b0;
        for (int l = 0; l < WAY_BITS; l++) begin
            b = tree_bits[node[IDXW-1:0]];
            victim_way[WAY_BITS-1-l] = b;
            node = 2 * node + 1 + int'(b);
        end
    end

    // Update: each node on the accessed path points away from the accessed way.
    always_comb begin : update_walk
        int   node;
        logic b;
        next_bits = tree_bits;
        node      = 0;
        b         = 1'b0;
        for (int l = 0; l < WAY_BITS; l++) begin
            b = hit_way[WAY_BITS-1-l];
            next_bits[node[IDXW-1:0]] = ~b;
            node = 2 * node + 1 + int'(b);
        end
    end

endmodule

// File: rtl/d_cache_wb_plru_nway.sv
// Write-back, write-allocate N-way set-associative data cache with tree PLRU.
// A miss writes back a dirty victim, refills the line word by word, then the held request replays as a hit.
module d_cache_wb_plru_nway
    import d_cache_pkg::*;
#(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 4,
    parameter int WAY_BITS     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    output logic [31:0] cpu_data_rdata,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    output logic        cache_data_req,
    output logic        cache_data_wr,
    output logic [1:0]  cache_data_size,
    output logic [31:0] cache_data_addr,
    output logic [31:0] cache_data_wdata,
    input  logic [31:0] cache_data_rdata,
    input  logic        cache_data_addr_ok,
    input  logic        cache_data_data_ok
);

    localparam int SETS       = 1 << INDEX_WIDTH;
    localparam int WORD_BITS  = OFFSET_WIDTH - 2;
    localparam int LINE_WORDS = 1 << WORD_BITS;
    localparam int WAYS       = 1 << WAY_BITS;
    localparam int NODES      = WAYS - 1;
    localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;

    state_t state, state_n;

    logic [31:0]          data_q  [WAYS][SETS][LINE_WORDS];
    logic [TAG_WIDTH-1:0] tag_q   [WAYS][SETS];
    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-1:0]      dirty_q [SETS];
    logic [NODES-1:0]     plru_q  [SETS];

    logic [TAG_WIDTH-1:0]   miss_tag, vict_tag;
    logic [INDEX_WIDTH-1:0] miss_idx;
    logic [WAY_BITS-1:0]    vict_way;
    logic [WORD_BITS-1:0]   cnt;
    logic                   addr_sent;

    logic [TAG_WIDTH-1:0]   req_tag;
    logic [INDEX_WIDTH-1:0] req_idx;
    logic [WORD_BITS-1:0]   req_word;
    logic [WAYS-1:0]        set_valid, set_dirty, way_hit;
    logic [WAY_BITS-1:0]    hit_way, inv_way, plru_victim, victim;
    logic [NODES-1:0]       plru_next;
    logic                   inv_found, any_hit, miss, xfer_done, last_word;
    logic [3:0]             wmask;

    assign req_tag   = cpu_data_addr[31 -: TAG_WIDTH];
    assign req_idx   = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_word  = cpu_data_addr[2 +: WORD_BITS];
    assign set_valid = valid_q[req_idx];
    assign set_dirty = dirty_q[req_idx];
    assign wmask     = byte_mask(cpu_data_size, cpu_data_addr[1:0]);

    always_comb begin
        way_hit   = '0;
        hit_way   = '0;
        inv_way   = '0;
        inv_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = set_valid[w] && (tag_q[w][req_idx] == req_tag);
        end
        // Descending scan so the lowest-numbered match wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) hit_way = WAY_BITS'(w);
            if (!set_valid[w]) begin
                inv_way   = WAY_BITS'(w);
                inv_found = 1'b1;
            end
        end
    end

    plru_tree #(.WAY_BITS(WAY_BITS)) u_plru (
        .tree_bits  (plru_q[req_idx]),
        .hit_way    (hit_way),
        .victim_way (plru_victim),
        .next_bits  (plru_next)
    );

    assign victim  = inv_found ? inv_way : plru_victim;
    assign any_hit = (state == ST_IDLE) && cpu_data_req && (|way_hit);
    assign miss    = (state == ST_IDLE) && cpu_data_req && !(|way_hit);

    assign cpu_data_addr_ok = any_hit;
    assign cpu_data_data_ok = any_hit;
    assign cpu_data_rdata   = any_hit ? data_q[hit_way][req_idx][req_word] : '0;

    // Bridge handshake: req is held until addr_ok, then dropped until data_ok closes the
    // transaction; addr_ok and data_ok may coincide. Only one transaction is ever outstanding.
    assign xfer_done = cache_data_data_ok && (addr_sent || (cache_data_req && cache_data_addr_ok));
    assign last_word = &cnt;

    always_comb begin
        cache_data_req   = 1'b0;
        cache_data_wr    = 1'b0;
        cache_data_addr  = '0;
        cache_data_wdata = '0;
        case (state)
            ST_WB: begin
                cache_data_req   = !addr_sent;
                cache_data_wr    = 1'b1;
                cache_data_addr  = {vict_tag, miss_idx, cnt, 2'b00};
                cache_data_wdata = data_q[vict_way][miss_idx][cnt];
            end
            ST_RF: begin
                cache_data_req  = !addr_sent;
                cache_data_addr = {miss_tag, miss_idx, cnt, 2'b00};
            end
            default: ;
        endcase
    end
    assign cache_data_size = SIZE_WORD;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (miss) state_n = (set_valid[victim] && set_dirty[victim]) ? ST_WB : ST_RF;
            ST_WB:   if (xfer_done && last_word) state_n = ST_RF;
            ST_RF:   if (xfer_done && last_word) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            cnt       <= '0;
            addr_sent <= 1'b0;
            miss_idx  <= '0;
            miss_tag  <= '0;
            vict_way  <= '0;
            vict_tag  <= '0;
        end else begin
            if (any_hit) begin
                plru_q[req_idx] <= plru_next;
                if (cpu_data_wr) dirty_q[req_idx][hit_way] <= 1'b1;
            end
            if (miss) begin
                miss_idx  <= req_idx;
                miss_tag  <= req_tag;
                vict_way  <= victim;
                vict_tag  <= tag_q[victim][req_idx];
                cnt       <= '0;
                addr_sent <= 1'b0;
            end
            if (state == ST_WB || state == ST_RF) begin
                if (xfer_done) begin
                    addr_sent <= 1'b0;
                    cnt       <= last_word ? '0 : cnt + 1'b1;
                    if (state == ST_RF && last_word) begin
                        valid_q[miss_idx][vict_way] <= 1'b1;
                        dirty_q[miss_idx][vict_way] <= 1'b0;
                    end
                end else if (cache_data_req && cache_data_addr_ok) begin
                    addr_sent <= 1'b1;
                end
            end
        end
    end

    // Line data and tags need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (any_hit && cpu_data_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) data_q[hit_way][req_idx][req_word][8*b +: 8] <= cpu_data_wdata[8*b +: 8];
            end
        end
        if (state == ST_RF && xfer_done) begin
            data_q[vict_way][miss_idx][cnt] <= cache_data_rdata;
            if (last_word) tag_q[vict_way][miss_idx] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_d_cache_wb_plru_nway.sv
// Directed bench for the write-back PLRU data cache: a 4-way instance and an 8-way instance,
// each behind a small sram-like bridge model backed by a shared word memory.
module tb_d_cache_wb_plru_nway;
    import d_cache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       c_req = '0, c_wr = '0, c_aok, c_dok;
    logic [1:0][1:0]  c_size = '0;
    logic [1:0][31:0] c_addr = '0, c_wdata = '0, c_rdata;
    logic [1:0]       b_req, b_wr, b_aok = '0, b_dok = '0;
    logic [1:0][1:0]  b_size;
    logic [1:0][31:0] b_addr, b_wdata, b_rdata = '0;

    int n_pass  = 0;
    int n_total = 0;

    d_cache_wb_plru_nway dut0 (
        .clk(clk), .rst(rst),
        .cpu_data_req(c_req[0]), .cpu_data_wr(c_wr[0]), .cpu_data_size(c_size[0]),
        .cpu_data_addr(c_addr[0]), .cpu_data_wdata(c_wdata[0]), .cpu_data_rdata(c_rdata[0]),
        .cpu_data_addr_ok(c_aok[0]), .cpu_data_data_ok(c_dok[0]),
        .cache_data_req(b_req[0]), .cache_data_wr(b_wr[0]), .cache_data_size(b_size[0]),
        .cache_data_addr(b_addr[0]), .cache_data_wdata(b_wdata[0]), .cache_data_rdata(b_rdata[0]),
        .cache_data_addr_ok(b_aok[0]), .cache_data_data_ok(b_dok[0])
    );

    d_cache_wb_plru_nway #(.WAY_BITS(3)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_data_req(c_req[1]), .cpu_data_wr(c_wr[1]), .cpu_data_size(c_size[1]),
        .cpu_data_addr(c_addr[1]), .cpu_data_wdata(c_wdata[1]), .cpu_data_rdata(c_rdata[1]),
        .cpu_data_addr_ok(c_aok[1]), .cpu_data_data_ok(c_dok[1]),
        .cache_data_req(b_req[1]), .cache_data_wr(b_wr[1]), .cache_data_size(b_size[1]),
        .cache_data_addr(b_addr[1]), .cache_data_wdata(b_wdata[1]), .cache_data_rdata(b_rdata[1]),
        .cache_data_addr_ok(b_aok[1]), .cache_data_data_ok(b_dok[1])
    );

    // Backing memory: untouched words read as addr ^ 0x5A5A0000.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;
    txn_t log0[$];
    txn_t log1[$];

    // Bridge model: alternates between same-cycle data_ok and data_ok one cycle after addr_ok.
    initial begin : bridge
        bit          pend [2];
        bit          fast [2];
        logic [31:0] pend_addr [2];
        txn_t        t;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; fast[p] = 0; pend_addr[p] = '0;
        end
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                b_aok[p] = 1'b0;
                b_dok[p] = 1'b0;
                if (rst) begin
                    pend[p] = 0;
                end else if (pend[p]) begin
                    b_dok[p]   = 1'b1;
                    b_rdata[p] = mem_rd(pend_addr[p]);
                    pend[p]    = 0;
                end else if (b_req[p]) begin
                    b_aok[p] = 1'b1;
                    t = '{wr: b_wr[p], addr: b_addr[p], wdata: b_wdata[p]};
                    if (p == 0) log0.push_back(t);
                    else        log1.push_back(t);
                    if (b_wr[p]) mem[b_addr[p]] = b_wdata[p];
                    if (fast[p]) begin
                        b_dok[p]   = 1'b1;
                        b_rdata[p] = mem_rd(b_addr[p]);
                    end else begin
                        pend[p]      = 1;
                        pend_addr[p] = b_addr[p];
                    end
                    fast[p] = !fast[p];
                end
            end
        end
    end

    task automatic cpu_access(input int p, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output int cycles,
                              output logic ok, output logic dok, output logic breq);
        @(negedge clk);
        c_req[p] = 1'b1; c_wr[p] = wr; c_size[p] = size; c_addr[p] = addr; c_wdata[p] = wdata;
        ok = 1'b0; dok = 1'b0; breq = 1'b0; rdata = '0; cycles = 0;
        while (!ok && cycles < 200) begin
            #1;
            if (c_aok[p]) begin
                ok = 1'b1; dok = c_dok[p]; rdata = c_rdata[p]; breq = b_req[p];
            end else begin
                @(negedge clk);
                cycles++;
            end
        end
        @(posedge clk);
        #1;
        c_req[p] = 1'b0; c_wr[p] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_total++; if (c_aok[0] !== 1'b0) $display("FAIL reset_addr_ok: got %b expected 0", c_aok[0]); else n_pass++;
        n_total++; if (c_dok[0] !== 1'b0) $display("FAIL reset_data_ok: got %b expected 0", c_dok[0]); else n_pass++;
        n_total++; if (c_rdata[0] !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", c_rdata[0]); else n_pass++;
        n_total++; if (b_req[0] !== 1'b0) $display("FAIL reset_bridge_req: got %b expected 0", b_req[0]); else n_pass++;
        n_total++; if (b_wr[0] !== 1'b0) $display("FAIL reset_bridge_wr: got %b expected 0", b_wr[0]); else n_pass++;
        n_total++; if (b_addr[0] !== 32'h0) $display("FAIL reset_bridge_addr: got %h expected 0", b_addr[0]); else n_pass++;
        n_total++; if (b_size[0] !== 2'b10) $display("FAIL reset_bridge_size: got %b expected 10", b_size[0]); else n_pass++;
        n_total++; if (b_size[1] !== 2'b10) $display("FAIL reset_bridge_size_8way: got %b expected 10", b_size[1]); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        logic [31:0] rd; int cyc; logic ok, dok, breq; int n0;
        n0 = log0.size();
        cpu_access(0, 1'b0, SIZE_WORD, 32'h1000_0004, 32'h0, rd, cyc, ok, dok, breq);
        n_total++; if (ok !== 1'b1 || dok !== 1'b1) $display("FAIL cold_ok: got %b/%b expected 1/1", ok, dok); else n_pass++;
        n_total++; if (rd !== 32'h4A5A_0004) $display("FAIL cold_rdata: got %h expected 4a5a0004", rd); else n_pass++;
        n_total++; if (log0.size() - n0 !== 4) $display("FAIL cold_txn_count: got %0d expected 4", log0.size() - n0); else n_pass++;
        for (int i = 0; i < 4 && n0 + i < log0.size(); i++) begin
            n_total++;
            if (log0[n0+i].wr !== 1'b0 || log0[n0+i].addr !== 32'h1000_0000 + 32'(4*i))
                $display("FAIL cold_read_%0d: got wr=%b addr=%h expected wr=0 addr=%h", i, log0[n0+i].wr, log0[n0+i].addr, 32'h1000_0000 + 32'(4*i));
            else n_pass++;
        end
    endtask

    task automatic test_hit_repeat();
        logic [31:0] rd; int cyc; logic ok, dok, breq; int n0;
        n0 = log0.size();
        cpu_access(0, 1'b0, SIZE_WORD, 32'h1000_0004, 32'h0, rd, cyc, ok, dok, breq);
        n_total++; if (cyc !== 0 || ok !== 1'b1 || dok !== 1'b1) $display("FAIL hit_same_cycle: got wait=%0d ok=%b dok=%b expected 0/1/1", cyc, ok, dok); else n_pass++;
        n_total++; if (breq !== 1'b0 || log0.size() !== n0) $display("FAIL hit_no_bridge: got req=%b txns=%0d expected 0/0", breq, log0.size() - n0); else n_pass++;
        n_total++; if (rd !== 32'h4A5A_0004) $display("FAIL hit_rdata: got %h expected 4a5a0004", rd); else n_pass++;
    endtask

    task automatic test_store_hit();
        logic [31:0] rd; int cyc; logic ok, dok, breq;
        cpu_access(0, 1'b1, SIZE_BYTE, 32'h1000_0005, 32'h0000_AB00, rd, cyc, ok, dok, breq);
        n_total++; if (cyc !== 0 || ok !== 1'b1) $display("FAIL sb_hit: got wait=%0d ok=%b expected 0/1", cyc, ok); else n_pass++;
        cpu_access(0, 1'b0, SIZE_WORD, 32'h1000_0004, 32'h0, rd, cyc, ok, dok, breq);
        n_total++; if (rd !== 32'h4A5A_AB04) $display("FAIL sb_merge: got %h expected 4a5aab04", rd); else n_pass++;
        cpu_access(0, 1'b1, SIZE_HALF, 32'h1000_000A, 32'hBEEF_0000, rd, cyc, ok, dok, breq);
        cpu_access(0, 1'b0, SIZE_WORD, 32'h1000_0008, 32'h0, rd, cyc, ok, dok, breq);
        n_total++; if (rd !== 32'hBEEF_0008) $display("FAIL sh_merge: got %h expected beef0008", rd); else n_pass++;
        cpu_access(0, 1'b1, 2'd3, 32'h1000_000C, 32'h1234_5678, rd, cyc, ok, dok, breq);
        cpu_access(0, 1'b0, SIZE_WORD, 32'h1000_000C, 32'h0, rd, cyc, ok, dok, breq);
        n_total++; if (rd !== 32'h1234_5678) $display("FAIL size3_word: got %h expected 12345678", rd); else n_pass++;
    endtask

    task automatic test_eviction();
        logic [31:0] rd; int cyc; logic ok, dok, breq; int n0;
        logic [31:0] exp_wb [4];
        logic [31:0] a;
        exp_wb[0] = 32'h4A5A_0000; exp_wb[1] = 32'h4A5A_AB04;
        exp_wb[2] = 32'hBEEF_0008; exp_wb[3] = 32'h1234_5678;
        for (int k = 1; k < 4; k++) begin
            a = 32'h1000_0000 + 32'(k) * 32'h800;
            cpu_access(0, 1'b0, SIZE_WORD, a, 32'h0, rd, cyc, ok, dok, breq);
            n_total++; if (ok !== 1'b1 || rd !== (a ^ 32'h5A5A_0000)) $display("FAIL fill_%0d: got ok=%b rd=%h expected 1/%h", k, ok, rd, a ^ 32'h5A5A_0000); else n_pass++;
        end
        n0 = log0.size();
        cpu_access(0, 1'b0, SIZE_WORD, 32'h1000_2000, 32'h0, rd, cyc, ok, dok, breq);
        n_total++; if (rd !== 32'h4A5A_2000) $display("FAIL evict_rdata: got %h expected 4a5a2000", rd); else n_pass++;
        n_total++; if (log0.size() - n0 !== 8) $display("FAIL evict_txn_count: got %0d expected 8", log0.size() - n0); else n_pass++;
        for (int i = 0; i < 4 && n0 + 4 + i < log0.size(); i++) begin
            n_total++;
            if (log0[n0+i].wr !== 1'b1 || log0[n0+i].addr !== 32'h1000_0000 + 32'(4*i) || log0[n0+i].wdata !== exp_wb[i])
                $display("FAIL evict_write_%0d: got wr=%b addr=%h data=%h expected 1/%h/%h", i, log0[n0+i].wr, log0[n0+i].addr, log0[n0+i].wdata, 32'h1000_0000 + 32'(4*i), exp_wb[i]);
            else n_pass++;
            n_total++;
            if (log0[n0+4+i].wr !== 1'b0 || log0[n0+4+i].addr !== 32'h1000_2000 + 32'(4*i))
                $display("FAIL evict_read_%0d: got wr=%b addr=%h expected 0/%h", i, log0[n0+4+i].wr, log0[n0+4+i].addr, 32'h1000_2000 + 32'(4*i));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] rd; int cyc; logic ok, dok, breq; int n0; int waited;
        @(negedge clk);
        c_req[0] = 1'b1; c_wr[0] = 1'b0; c_size[0] = SIZE_WORD; c_addr[0] = 32'h1000_0004;
        n0 = log0.size();
        waited = 0;
        while (log0.size() < n0 + 2 && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        n_total++; if (log0.size() < n0 + 2) $display("FAIL midrst_reach_read2: got %0d txns expected 2", log0.size() - n0); else n_pass++;
        rst = 1'b1;
        c_req[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_total++; if (b_req[0] !== 1'b0) $display("FAIL midrst_bridge_req: got %b expected 0", b_req[0]); else n_pass++;
        n_total++; if (dut0.state !== ST_IDLE) $display("FAIL midrst_state: got %0d expected %0d", dut0.state, ST_IDLE); else n_pass++;
        rst = 1'b0;
        n0 = log0.size();
        cpu_access(0, 1'b0, SIZE_WORD, 32'h1000_0004, 32'h0, rd, cyc, ok, dok, breq);
        n_total++; if (log0.size() - n0 !== 4) $display("FAIL midrst_remiss_count: got %0d expected 4", log0.size() - n0); else n_pass++;
        n_total++; if (log0.size() > n0 && (log0[n0].wr !== 1'b0 || log0[n0].addr !== 32'h1000_0000)) $display("FAIL midrst_remiss_addr: got %b/%h expected 0/10000000", log0[n0].wr, log0[n0].addr); else n_pass++;
        n_total++; if (rd !== 32'h4A5A_AB04) $display("FAIL midrst_rdata: got %h expected 4a5aab04", rd); else n_pass++;
    endtask

    task automatic test_eight_way();
        logic [31:0] rd; int cyc; logic ok, dok, breq; int n0;
        logic [31:0] a;
        for (int k = 0; k < 9; k++) begin
            a = 32'h2000_0000 + 32'(k) * 32'h800;
            n0 = log1.size();
            cpu_access(1, 1'b0, SIZE_WORD, a, 32'h0, rd, cyc, ok, dok, breq);
            n_total++; if (ok !== 1'b1 || rd !== (a ^ 32'h5A5A_0000)) $display("FAIL way8_fill_%0d: got ok=%b rd=%h expected 1/%h", k, ok, rd, a ^ 32'h5A5A_0000); else n_pass++;
            n_total++; if (log1.size() - n0 !== 4) $display("FAIL way8_fill_txns_%0d: got %0d expected 4", k, log1.size() - n0); else n_pass++;
        end
        for (int k = 1; k < 8; k++) begin
            a = 32'h2000_0000 + 32'(k) * 32'h800;
            n0 = log1.size();
            cpu_access(1, 1'b0, SIZE_WORD, a, 32'h0, rd, cyc, ok, dok, breq);
            n_total++; if (cyc !== 0 || log1.size() !== n0) $display("FAIL way8_keep_%0d: got wait=%0d txns=%0d expected 0/0", k, cyc, log1.size() - n0); else n_pass++;
        end
        n0 = log1.size();
        cpu_access(1, 1'b0, SIZE_WORD, 32'h2000_0000, 32'h0, rd, cyc, ok, dok, breq);
        n_total++; if (log1.size() - n0 !== 4) $display("FAIL way8_way0_evicted: got %0d txns expected 4", log1.size() - n0); else n_pass++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_repeat();
        test_store_hit();
        test_eviction();
        test_reset_mid_refill();
        test_eight_way();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
